// File: rtl/fft_addr_seq_pkg.sv
// Shared types and constants for the FFT address sequencer.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BITREV = 2'd1,
    ST_BFLY   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic OP_SWAP = 1'b0;
  localparam logic OP_BFLY = 1'b1;

  // Sizes for the default 8-point configuration; fft_len() covers other sizes.
  localparam int DEF_FFTSIZ = 3;
  localparam int N          = 1 << DEF_FFTSIZ;
  localparam int NH         = N / 2;

  function automatic int fft_len(input int fftsiz);
    return 1 << fftsiz;
  endfunction

endpackage

// File: rtl/fft_addr_seq_bit_rev.sv
// Combinational W-bit index reverser used to pair elements in the swap pass.
module bit_rev #(
  parameter int W = 3
) (
  input  logic [W-1:0] idx,
  output logic [W-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int b = 0; b < W; b++) begin
      rev[b] = idx[W-1-b];
    end
  end

endmodule

// File: rtl/fft_addr_seq.sv
// Address sequencer for in-place radix-2 FFTs over interleaved re/im memory.
// Macro FFT_BITREV_EN includes the bit-reversal swap pass before the butterflies.
module fft_addr_seq
  import fft_seq_pkg::*;
#(
  parameter int MDATAW = 8,
  parameter int FFTSIZ = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MDATAW-1:0] base,
  input  logic              ready,
  output logic              valid,
  output logic              op,
  output logic [MDATAW-1:0] addr_a,
  output logic [MDATAW-1:0] addr_b,
  output logic [FFTSIZ-2:0] tw_idx,
  output logic [FFTSIZ-1:0] stage,
  output logic              busy,
  output logic              done
);

  localparam int LEN  = fft_len(FFTSIZ);
  localparam int HLEN = LEN / 2;
  localparam int TW   = FFTSIZ - 1;

`ifdef FFT_BITREV_EN
  localparam logic OP_IDLE = OP_SWAP;
`else
  localparam logic OP_IDLE = OP_BFLY;
`endif

  typedef logic [FFTSIZ-1:0] idx_t;

  state_t             state, state_n;
  idx_t               k, k_n, s, s_n;
  logic [MDATAW-1:0]  base_r, base_n;

  logic               valid_n, op_n, busy_n, done_n;
  logic [MDATAW-1:0]  addr_a_n, addr_b_n;
  logic [TW-1:0]      tw_n;
  idx_t               stage_n;
  idx_t               half_n, j_n, i_n;

`ifdef FFT_BITREV_EN
  idx_t rev_n;

  bit_rev #(.W(FFTSIZ)) u_bit_rev (
    .idx (k_n),
    .rev (rev_n)
  );
`endif

  // Outputs are registered from the next-state values, so a stalled op repeats exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      k      <= '0;
      s      <= '0;
      base_r <= '0;
      valid  <= 1'b0;
      op     <= OP_IDLE;
      addr_a <= '0;
      addr_b <= '0;
      tw_idx <= '0;
      stage  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      s      <= s_n;
      base_r <= base_n;
      valid  <= valid_n;
      op     <= op_n;
      addr_a <= addr_a_n;
      addr_b <= addr_b_n;
      tw_idx <= tw_n;
      stage  <= stage_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Skipped swap slots (valid low) always advance; real ops wait for ready.
  always_comb begin
    state_n = state;
    k_n     = k;
    s_n     = s;
    base_n  = base_r;
    case (state)
      ST_IDLE: begin
        if (start) begin
          base_n = base;
          k_n    = '0;
          s_n    = '0;
`ifdef FFT_BITREV_EN
          state_n = ST_BITREV;
`else
          state_n = ST_BFLY;
`endif
        end
      end
`ifdef FFT_BITREV_EN
      ST_BITREV: begin
        if (!valid || ready) begin
          if (k == idx_t'(LEN - 1)) begin
            state_n = ST_BFLY;
            k_n     = '0;
            s_n     = '0;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
`endif
      ST_BFLY: begin
        if (ready) begin
          if (k == idx_t'(HLEN - 1)) begin
            k_n = '0;
            if (s == idx_t'(FFTSIZ - 1)) begin
              state_n = ST_DONE;
            end else begin
              s_n = s + 1'b1;
            end
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    half_n   = idx_t'(1) << s_n;
    j_n      = k_n & (half_n - 1'b1);
    i_n      = ((k_n >> s_n) << (s_n + 1'b1)) | j_n;
    valid_n  = 1'b0;
    op_n     = OP_IDLE;
    addr_a_n = '0;
    addr_b_n = '0;
    tw_n     = '0;
    stage_n  = '0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    case (state_n)
`ifdef FFT_BITREV_EN
      ST_BITREV: begin
        busy_n = 1'b1;
        op_n   = OP_SWAP;
        if (k_n < rev_n) begin
          valid_n  = 1'b1;
          addr_a_n = base_n + MDATAW'({k_n, 1'b0});
          addr_b_n = base_n + MDATAW'({rev_n, 1'b0});
        end
      end
`endif
      ST_BFLY: begin
        busy_n   = 1'b1;
        valid_n  = 1'b1;
        op_n     = OP_BFLY;
        stage_n  = s_n;
        addr_a_n = base_n + MDATAW'({i_n, 1'b0});
        addr_b_n = base_n + MDATAW'({idx_t'(i_n + half_n), 1'b0});
        tw_n     = TW'(j_n << (TW - int'(s_n)));
      end
      ST_DONE: done_n = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fft_addr_seq.sv
// Directed, table-driven bench for fft_addr_seq (FFTSIZ=3, MDATAW=8).
module tb_fft_addr_seq;

  logic       clk = 1'b0;
  logic       rst, start, ready;
  logic [7:0] base;
  logic       valid, op, busy, done;
  logic [7:0] addr_a, addr_b;
  logic [1:0] tw_idx;
  logic [2:0] stage;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       valid;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] tw;
    logic [2:0] stage;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t tbl[0:23];
  int   nrec;
  int   boff;

`ifdef FFT_BITREV_EN
  localparam logic OPI = 1'b0;
`else
  localparam logic OPI = 1'b1;
`endif

  fft_addr_seq #(.MDATAW(8), .FFTSIZ(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (base),
    .ready  (ready),
    .valid  (valid),
    .op     (op),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .tw_idx (tw_idx),
    .stage  (stage),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic o, input logic [7:0] a,
                              input logic [7:0] b, input logic [1:0] tw,
                              input logic [2:0] st, input logic bz, input logic dn);
    exp_t e;
    e.valid = v; e.op = o; e.a = a; e.b = b; e.tw = tw;
    e.stage = st; e.busy = bz; e.done = dn;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] b, input logic rd);
    rst   = r;
    start = s;
    base  = b;
    ready = rd;
  endtask

  // Addresses are only meaningful when valid, except in idle where they must be zero.
  task automatic checkOutput(input string name, input int idx, input exp_t e);
    logic bad;
    checks++;
    bad = (valid !== e.valid) || (op !== e.op) || (busy !== e.busy) ||
          (done !== e.done) || (stage !== e.stage) || (tw_idx !== e.tw);
    if (e.valid || (!e.busy && !e.done))
      bad = bad || (addr_a !== e.a) || (addr_b !== e.b);
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got v=%b op=%b a=%h b=%h tw=%0d st=%0d busy=%b done=%b, want v=%b op=%b a=%h b=%h tw=%0d st=%0d busy=%b done=%b",
               name, idx, valid, op, addr_a, addr_b, tw_idx, stage, busy, done,
               e.valid, e.op, e.a, e.b, e.tw, e.stage, e.busy, e.done);
    end
  endtask

  task automatic fillTable();
    exp_t idle;
    int n;
    idle = mk(0, OPI, 8'h00, 8'h00, 0, 0, 0, 0);
    n = 0;
    tbl[n++] = idle;
`ifdef FFT_BITREV_EN
    tbl[n++] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[n++] = mk(1, 0, 8'h12, 8'h18, 0, 0, 1, 0);
    tbl[n++] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    tbl[n++] = mk(1, 0, 8'h16, 8'h1C, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tbl[n++] = mk(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    boff = 8;
`else
    boff = 0;
`endif
    tbl[n++] = mk(1, 1, 8'h10, 8'h12, 0, 0, 1, 0);
    tbl[n++] = mk(1, 1, 8'h14, 8'h16, 0, 0, 1, 0);
    tbl[n++] = mk(1, 1, 8'h18, 8'h1A, 0, 0, 1, 0);
    tbl[n++] = mk(1, 1, 8'h1C, 8'h1E, 0, 0, 1, 0);
    tbl[n++] = mk(1, 1, 8'h10, 8'h14, 0, 1, 1, 0);
    tbl[n++] = mk(1, 1, 8'h12, 8'h16, 2, 1, 1, 0);
    tbl[n++] = mk(1, 1, 8'h18, 8'h1C, 0, 1, 1, 0);
    tbl[n++] = mk(1, 1, 8'h1A, 8'h1E, 2, 1, 1, 0);
    tbl[n++] = mk(1, 1, 8'h10, 8'h18, 0, 2, 1, 0);
    tbl[n++] = mk(1, 1, 8'h12, 8'h1A, 1, 2, 1, 0);
    tbl[n++] = mk(1, 1, 8'h14, 8'h1C, 2, 2, 1, 0);
    tbl[n++] = mk(1, 1, 8'h16, 8'h1E, 3, 2, 1, 0);
    tbl[n++] = mk(0, OPI, 8'h00, 8'h00, 0, 0, 0, 1);
    tbl[n] = idle;
    nrec = n;
  endtask

  initial begin
    int hold, idx;
    fillTable();

    // Reset state, then start together with reset must not launch a run.
    applyStimulus(1, 0, 8'h00, 1);
    tick();
    tick();
    checkOutput("reset", 0, tbl[0]);
    applyStimulus(1, 1, 8'h10, 1);
    tick();
    checkOutput("rst_start", 0, tbl[0]);
    applyStimulus(0, 0, 8'h10, 1);
    tick();
    checkOutput("no_run", 0, tbl[0]);

    // Full transform with ready high: ops, done cycle, return to idle.
    applyStimulus(0, 1, 8'h10, 1);
    tick();
    applyStimulus(0, 0, 8'h10, 1);
    for (int c = 1; c <= nrec; c++) begin
      checkOutput("main", c, tbl[c]);
      tick();
    end

    // Backpressure on the stage-1 op (0x12,0x16) for 3 cycles.
    hold = boff + 6;
    applyStimulus(0, 1, 8'h10, 1);
    tick();
    applyStimulus(0, 0, 8'h10, 1);
    for (int c = 1; c <= nrec + 3; c++) begin
      ready = !(c >= hold && c < hold + 3);
      idx = (c <= hold) ? c : ((c <= hold + 3) ? hold : c - 3);
      checkOutput("bp", c, tbl[idx]);
      tick();
    end
    ready = 1'b1;

    // Start mid-run is ignored, then reset in stage 1 abandons the run.
    applyStimulus(0, 1, 8'h10, 1);
    tick();
    for (int c = 1; c <= boff + 5; c++) begin
      if (c == boff + 2) applyStimulus(0, 1, 8'h80, 1);
      else               applyStimulus(0, 0, 8'h10, 1);
      checkOutput("run_ign", c, tbl[c]);
      tick();
    end
    applyStimulus(1, 0, 8'h10, 1);
    tick();
    checkOutput("mid_rst", 0, tbl[0]);
    applyStimulus(0, 0, 8'h10, 1);
    tick();
    checkOutput("after_rst", 0, tbl[0]);

    // Base near the top of memory wraps modulo 256.
    applyStimulus(0, 1, 8'hFC, 1);
    tick();
    applyStimulus(0, 0, 8'hFC, 1);
    repeat (boff) tick();
    checkOutput("wrap", 0, mk(1, 1, 8'hFC, 8'hFE, 0, 0, 1, 0));
    tick();
    checkOutput("wrap", 1, mk(1, 1, 8'h00, 8'h02, 0, 0, 1, 0));
    repeat (12) tick();
    checkOutput("wrap_end", 0, tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_addr_seq.md
# fft_addr_seq

Address sequencer for in-place radix-2 FFTs held in data memory as interleaved real/imaginary pairs. Element k lives at `base + 2k` (real) and `base + 2k + 1` (imag). After one `start` pulse the block drives the processor's FFT datapath: an optional bit-reversal swap pass, then every butterfly of every stage. Each step carries two element addresses and a twiddle index. It does the stage-by-stage scheduling that the relative-address unit cannot do by itself.

## Interface
- `MDATAW`, 8: address/data width; must satisfy MDATAW ≥ FFTSIZ+1
- `FFTSIZ`, 3: log2 of FFT length N; must satisfy FFTSIZ ≥ 2
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a transform; sampled only in IDLE
- `base` in MDATAW: element-0 real address; captured with `start`
- `ready` in 1: datapath accepts the current op
- `valid` out 1: `op`/`addr_a`/`addr_b`/`tw_idx` are meaningful
- `op` out 1: 0 = SWAP (exchange elements), 1 = BFLY (butterfly a,b with twiddle)
- `addr_a` out MDATAW: real address of first element
- `addr_b` out MDATAW: real address of second element
- `tw_idx` out FFTSIZ-1: twiddle index (W_N^tw_idx); 0 for SWAP
- `stage` out FFTSIZ: current butterfly stage s; 0 during SWAP
- `busy` out 1: transform in progress
- `done` out 1: one-cycle pulse after the final accepted op

## Operation
- FSM states: IDLE → BITREV → BFLY → DONE → IDLE.
- **IDLE**
  - On `start`: latch `base`, clear index k and stage s, then go to BITREV (BFLY when the bit-reversal pass is compiled out).
  - `start` is ignored in every other state.
- **BITREV**
  - k steps 0..N-1, one value per cycle.
  - `valid` = (k < rev(k)), where rev reverses the FFTSIZ index bits.
  - Each swap pair is issued exactly once; palindromic and upper-half indices are skipped with `valid` low.
  - When `valid` is high, `addr_a` = base+2k and `addr_b` = base+2·rev(k).
  - k advances when `!valid` or (`valid`&&`ready`).
  - After k=N-1 advances: go to BFLY with k=0, s=0.
- **BFLY**
  - k steps 0..N/2-1 inside stage s, with half = 2^s, j = k mod half, i = ((k>>s)<<(s+1)) | j.
  - `addr_a` = base+2i, `addr_b` = base+2(i+half), `tw_idx` = j<<(FFTSIZ-1-s).
  - `valid` is always high in this state; advance only on `ready`.
  - After k=N/2-1: s increments and k clears. After s=FFTSIZ-1 completes: go to DONE.
- **DONE**: `done`=1 for one cycle, `busy`=0, then IDLE.
- Address arithmetic is modulo 2^MDATAW: a base near the top of memory wraps silently, with no flag.
- All outputs are registered.

## Timing
- Reset, or IDLE: `valid`, `op`, `addr_a`, `addr_b`, `tw_idx`, `stage`, `busy`, `done` all 0.
- Latency: `start` sampled at edge 0 → first op state (k=0) present in cycle 1, with `busy`=1.
- Hold rule: while `valid`&&!`ready`, every output stays stable. Nothing changes until the handshake completes.
- One op is accepted per cycle at most; back-to-back accepts are allowed.
- With `ready` tied high the transform occupies N + (N/2)·FFTSIZ cycles, followed by the `done` cycle.
- `rst` asserted in any state returns to IDLE at the next edge. Any partial transform is abandoned, with no `done`.
- `start` and `rst` high together: reset wins.

## Configuration
- Macro: `FFT_BITREV_EN`.
- **Defined**
  - BITREV phase present.
  - Cycle count with `ready` high: N + (N/2)·FFTSIZ, plus the `done` cycle.
- **Undefined**
  - BITREV logic is removed; `start` goes straight to BFLY.
  - Input must already be in bit-reversed order, for example loaded through the relative-address unit's inverted-index path.
  - Cycle count: (N/2)·FFTSIZ, plus the `done` cycle.
  - `op` is constant 1.

## Structure
- Package `fft_seq_pkg` holds:
  - the state encoding (IDLE, BITREV, BFLY, DONE);
  - op codes OP_SWAP=0 and OP_BFLY=1;
  - helper constants N = 1<<FFTSIZ and NH = N/2.
- Sub-module `bit_rev`: parameterised FFTSIZ-bit reverser. It is purely combinational and used for rev(k).

## Test plan
All scenarios use FFTSIZ=3, MDATAW=8, base=0x10, `ready` held 1, `FFT_BITREV_EN` defined unless stated otherwise.
- **Swap pass**: `start` → exactly two SWAPs, (0x12,0x18) then (0x16,0x1C); k=0,2,4,5,6,7 produce `valid` low.
- **Stages 0 and 1**
  - Stage 0: (0x10,0x12), (0x14,0x16), (0x18,0x1A), (0x1C,0x1E), all with tw 0.
  - Stage 1: (0x10,0x14,tw0), (0x12,0x16,tw2), (0x18,0x1C,tw0), (0x1A,0x1E,tw2).
- **Stage 2 and completion**: (0x10,0x18,tw0), (0x12,0x1A,tw1), (0x14,0x1C,tw2), (0x16,0x1E,tw3); then `done` high in cycle 21 only.
- **Backpressure**: drop `ready` for 3 cycles on the stage-1 op (0x12,0x16) → outputs held; the sequence resumes unchanged and `done` is delayed by 3.
- **Reset mid-run plus wrap**
  - Assert `rst` during stage 1 → next cycle all outputs 0 and state IDLE; `start` during a run is ignored.
  - Restart with base=0xFC → stage-0 first op is (0xFC,0xFE), second is (0x00,0x02).
- **Bit-reversal compiled out**: `FFT_BITREV_EN` undefined → first op appears in cycle 1 as BFLY (0x10,0x12); `done` in cycle 13.
